div_dp_issue: RTL and testbench
===============================

# div_dp_issue

Operand front end for the multi-cycle double-precision divider. Buffers IEEE-754 binary64 operand pairs in a small in-order FIFO and resolves special operands (NaN, infinity, zero, subnormal) locally. Only normal/normal pairs are issued to the divider, with a one-cycle start pulse and operands held stable. The divider result is captured after a fixed latency and presented on a valid/ready output, so results leave in arrival order.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, >= 2.
- LATENCY, 30: cycles from the div_start-high cycle to a valid div_z; >= 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready.
- in_a  in  64  dividend, binary64.
- in_b  in  64  divisor, binary64.
- div_start  out  1  one-cycle issue pulse to the divider.
- div_a  out  64  dividend to the divider; stable from issue until capture.
- div_b  out  64  divisor to the divider; stable from issue until capture.
- div_z  in  64  divider result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_z  out  64  quotient, binary64.
- out_special  out  1  result was produced by the bypass path, not the divider.

## Operation
- FIFO
  - count register, 0..DEPTH, with read and write pointers that wrap modulo DEPTH.
  - in_ready = (count < DEPTH), decoded from registered count only. A full FIFO refuses a push even in a cycle that pops.
  - A push and a pop in the same cycle leave count unchanged.
- Classification of the FIFO head. Exp is [62:52], mant is [51:0].
  - NaN: exp = 0x7FF and mant != 0.
  - Inf: exp = 0x7FF and mant = 0.
  - Zero: exp = 0. Subnormals are flushed to zero.
  - Normal: anything else.
- Bypass rules, applied in priority order. s = a[63] ^ b[63].
  - Either operand NaN, inf/inf, or zero/zero: 0x7FF8_0000_0000_0000, with sign 0.
  - a Inf: {s, 0x7FF, 52'h0}.
  - b Inf: {s, 63'h0}.
  - b Zero: {s, 0x7FF, 52'h0}.
  - a Zero: {s, 63'h0}.
- States:
  - S_IDLE: when count != 0, pop the head.
    - Special operands: load out_z with the bypass value, set out_special=1, go to S_HOLD.
    - Normal operands: load div_a/div_b, set out_special=0, go to S_ISSUE.
  - S_ISSUE: div_start=1 for exactly this cycle. Load the wait counter with LATENCY-1, go to S_WAIT.
  - S_WAIT: decrement the counter. When it is 0, register div_z into out_z and go to S_HOLD.
  - S_HOLD: out_valid=1. On out_ready, go to S_IDLE.
- out_z and out_special are stable while out_valid=1.
- div_a/div_b change only on an S_IDLE pop of a normal pair.
- The counter width is clog2(LATENCY).
- Reset values, asserted immediately on reset low:
  - state S_IDLE, count 0, pointers 0.
  - in_ready 0 while reset is asserted, 1 after release.
  - div_start 0, div_a 0, div_b 0.
  - out_valid 0, out_z 0, out_special 0.
- Reset mid-operation discards FIFO contents and any in-flight division. The integrator drives the divider's reset from the same source.

## Timing
- Pushes continue during S_ISSUE, S_WAIT and S_HOLD until the FIFO is full.
- Special path: pair pushed in cycle t into an empty FIFO:
  - popped in S_IDLE at t+1;
  - out_valid=1 from t+2.
- Normal path: same push at t:
  - pop at t+1;
  - div_start high in cycle c = t+2;
  - div_z sampled at the end of cycle c+LATENCY;
  - out_valid=1 from c+LATENCY+1.
- Back-to-back throughput, one result per:
  - 2 cycles for specials with out_ready held at 1;
  - LATENCY+3 cycles for normals.
- out_valid falls the cycle after the out_ready handshake. The next head is popped in that same S_IDLE cycle.

## Test plan
- Normal path: push a=0x4018_0000_0000_0000 (6.0), b=0x4000_0000_0000_0000 (2.0).
  - Bench divider model returns 0x4008_0000_0000_0000 (3.0).
  - Required: div_start high exactly one cycle at t+2, with div_a/div_b equal to the inputs.
  - Required: out_z=0x4008_0000_0000_0000, out_special=0, out_valid at t+2+LATENCY+1.
- Specials, one per push with out_ready=1, checking out_z and out_special=1 with no div_start:
  - 1.0/+0 -> 0x7FF0_0000_0000_0000.
  - -1.0/+Inf -> 0x8000_0000_0000_0000.
  - 0/0 -> 0x7FF8_0000_0000_0000.
  - NaN/2.0 -> 0x7FF8_0000_0000_0000.
  - subnormal 0x0000_0000_0000_0001 / 2.0 -> 0x0000_0000_0000_0000.
- Ordering: push normal, special, normal back-to-back.
  - Required: results exit in push order.
  - Required: the special waits behind the first division.
- Backpressure: hold out_ready=0 and push DEPTH+2 pairs.
  - Required: in_ready falls after DEPTH+1 accepted (DEPTH in the FIFO, one in flight).
  - Required: out_z stays stable.
  - Required: pushing with count=DEPTH in the same cycle as a pop is refused.
- Reset mid-S_WAIT with 2 entries queued.
  - Required: out_valid=0, div_start=0, in_ready=0 during reset.
  - Required after release: in_ready=1, no result emitted, next push processed normally.

Source files
------------

// File: rtl/div_dp_issue_if.sv
// Handshake bundle for the divider front end: operand input, divider issue/return, result output.
interface div_dp_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        div_start;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic [63:0] div_z;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_z;
  logic        out_special;

  modport master (
    output in_valid, in_a, in_b, div_z, out_ready,
    input  in_ready, div_start, div_a, div_b, out_valid, out_z, out_special
  );

  modport slave (
    input  in_valid, in_a, in_b, div_z, out_ready,
    output in_ready, div_start, div_a, div_b, out_valid, out_z, out_special
  );
endinterface

// File: rtl/div_dp_issue.sv
// Binary64 divide front end: in-order operand FIFO, local resolution of special operands,
// fixed-latency issue/capture of normal pairs to the external divider.
module div_dp_issue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 30
) (
  input logic           clk,
  input logic           rst_n,
  div_dp_issue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(LATENCY);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [LW-1:0] WAIT_LOAD = LW'(LATENCY - 1);
  localparam logic [63:0]   QNAN      = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [63:0]   memA_q [DEPTH];
  logic [63:0]   memB_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] wait_q, wait_d;
  logic [63:0]   divA_q, divA_d, divB_q, divB_d, outZ_q, outZ_d;
  logic          outSpecial_q, outSpecial_d;
  logic          push, pop;
  logic [63:0]   headA, headB, bypassZ;
  logic          isSpecial, sgn;
  logic          aNan, bNan, aInf, bInf, aZero, bZero;

  assign bus.in_ready    = rst_n & (count_q < FULL);
  assign push            = bus.in_valid & bus.in_ready;
  assign headA           = memA_q[rdPtr_q];
  assign headB           = memB_q[rdPtr_q];
  assign bus.div_start   = (state_q == S_ISSUE);
  assign bus.out_valid   = (state_q == S_HOLD);
  assign bus.div_a       = divA_q;
  assign bus.div_b       = divB_q;
  assign bus.out_z       = outZ_q;
  assign bus.out_special = outSpecial_q;

  // Subnormals have a zero exponent and therefore classify as zero.
  assign aNan  = (headA[62:52] == 11'h7FF) && (headA[51:0] != 52'd0);
  assign bNan  = (headB[62:52] == 11'h7FF) && (headB[51:0] != 52'd0);
  assign aInf  = (headA[62:52] == 11'h7FF) && (headA[51:0] == 52'd0);
  assign bInf  = (headB[62:52] == 11'h7FF) && (headB[51:0] == 52'd0);
  assign aZero = (headA[62:52] == 11'd0);
  assign bZero = (headB[62:52] == 11'd0);
  assign sgn   = headA[63] ^ headB[63];

  always_comb begin
    isSpecial = 1'b1;
    bypassZ   = QNAN;
    if (aNan || bNan || (aInf && bInf) || (aZero && bZero)) begin
      bypassZ = QNAN;
    end else if (aInf) begin
      bypassZ = {sgn, 11'h7FF, 52'd0};
    end else if (bInf) begin
      bypassZ = {sgn, 63'd0};
    end else if (bZero) begin
      bypassZ = {sgn, 11'h7FF, 52'd0};
    end else if (aZero) begin
      bypassZ = {sgn, 63'd0};
    end else begin
      isSpecial = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    wait_d       = wait_q;
    divA_d       = divA_q;
    divB_d       = divB_q;
    outZ_d       = outZ_q;
    outSpecial_d = outSpecial_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (isSpecial) begin
            outZ_d       = bypassZ;
            outSpecial_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            divA_d       = headA;
            divB_d       = headB;
            outSpecial_d = 1'b0;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          outZ_d  = bus.div_z;
          state_d = S_HOLD;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      wait_q       <= '0;
      divA_q       <= '0;
      divB_q       <= '0;
      outZ_q       <= '0;
      outSpecial_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wait_q       <= wait_d;
      divA_q       <= divA_d;
      divB_q       <= divB_d;
      outZ_q       <= outZ_d;
      outSpecial_q <= outSpecial_d;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wrPtr_q] <= bus.in_a;
      memB_q[wrPtr_q] <= bus.in_b;
    end
  end
endmodule

// File: tb/tb_div_dp_issue.sv
// Self-checking bench for div_dp_issue: directed timing/special/ordering/backpressure/reset
// steps plus a randomized phase scored against a queue-based reference model.
module tb_div_dp_issue;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 30;
  localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] MONE = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] SIX  = 64'h4018_0000_0000_0000;
  localparam logic [63:0] FOUR = 64'h4010_0000_0000_0000;
  localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] ANAN = 64'h7FF0_0000_0000_0001;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef struct {
    logic [63:0] z;
    logic        sp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  div_dp_issue_if bus ();
  div_dp_issue #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nAsserts = 0;
  int nFails = 0;
  int divStarts = 0;
  int divAge = 1000;
  logic [63:0] latchA, latchB;
  logic prevStart = 1'b0;
  exp_t expQ[$];
  logic prevValid = 1'b0, prevReady = 1'b0, prevSp = 1'b0;
  logic [63:0] prevZ = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] quot(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  // Reference quotient: special-operand rules first, otherwise a real-valued divide.
  function automatic void refModel(input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] z, output logic sp);
    logic aNan = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    logic bNan = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    logic aInf = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
    logic bInf = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
    logic aZero = (a[62:52] == 0);
    logic bZero = (b[62:52] == 0);
    logic s = a[63] ^ b[63];
    sp = 1'b1;
    if (aNan || bNan || (aInf && bInf) || (aZero && bZero)) z = QNAN;
    else if (aInf || bZero) z = {s, 11'h7FF, 52'd0};
    else if (bInf || aZero) z = {s, 63'd0};
    else begin
      sp = 1'b0;
      z  = quot(a, b);
    end
  endfunction

  function automatic logic [63:0] randOp();
    logic        s = 1'($urandom);
    logic [51:0] m = {20'($urandom), 32'($urandom)};
    case ($urandom_range(0, 9))
      0: return {s, 11'd0, 52'd0};
      1: return {s, 11'd0, m | 52'd1};
      2: return {s, 11'h7FF, 52'd0};
      3: return {s, 11'h7FF, m | 52'd1};
      default: return {s, 11'($urandom_range(1, 2046)), m};
    endcase
  endfunction

  // Divider model: correct quotient only in the exact capture cycle, noise otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      divAge    = 1000;
      prevStart = 1'b0;
      bus.div_z = {$urandom, $urandom};
    end else begin
      if (bus.div_start) begin
        chk("div_start_pulse", 64'(prevStart), 64'd0);
        divStarts++;
        divAge = 0;
        latchA = bus.div_a;
        latchB = bus.div_b;
      end else if (divAge < 1000) begin
        divAge++;
      end
      prevStart = bus.div_start;
      if (divAge == LATENCY) begin
        chk("div_a_stable", bus.div_a, latchA);
        chk("div_b_stable", bus.div_b, latchB);
        bus.div_z = quot(latchA, latchB);
      end else begin
        bus.div_z = {$urandom, $urandom};
      end
    end
  end

  task automatic tick();
    exp_t e;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        refModel(bus.in_a, bus.in_b, e.z, e.sp);
        expQ.push_back(e);
      end
      if (prevValid && !prevReady && bus.out_valid) begin
        chk("out_z_stable", bus.out_z, prevZ);
        chk("out_special_stable", 64'(bus.out_special), 64'(prevSp));
      end
      if (bus.out_valid && bus.out_ready) begin
        nAsserts++;
        assert (expQ.size() > 0) else begin
          nFails++;
          $error("FAIL unexpected_result observed=%h expected=none", bus.out_z);
        end
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          chk("sb_out_z", bus.out_z, e.z);
          chk("sb_out_special", 64'(bus.out_special), 64'(e.sp));
        end
      end
      prevValid = bus.out_valid;
      prevReady = bus.out_ready;
      prevZ     = bus.out_z;
      prevSp    = bus.out_special;
    end else begin
      prevValid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic push1(input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 200 && bus.in_ready !== 1'b1; i++) tick();
    chk("push_accept", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(input int budget, input string tag);
    for (int i = 0; i < budget && bus.out_valid !== 1'b1; i++) tick();
    chk(tag, 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] spA[5], spB[5], spZ[5];
    logic [63:0] ordA[3], ordB[3], ordZ[3];
    logic        ordSp[3];
    logic [63:0] bpA[DEPTH+2], bpB[DEPTH+2];
    int startsBefore, accepted, seenValid;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset values while reset is held.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_div_start", 64'(bus.div_start), 64'd0);
    chk("rst_div_a", bus.div_a, 64'd0);
    chk("rst_div_b", bus.div_b, 64'd0);
    chk("rst_out_z", bus.out_z, 64'd0);
    chk("rst_out_special", 64'(bus.out_special), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Normal path timing: push at t, start at t+2, result valid at t+3+LATENCY.
    bus.in_valid = 1'b1;
    bus.in_a     = SIX;
    bus.in_b     = TWO;
    chk("norm_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("norm_no_start_t1", 64'(bus.div_start), 64'd0);
    tick();
    chk("norm_start_t2", 64'(bus.div_start), 64'd1);
    chk("norm_div_a", bus.div_a, SIX);
    chk("norm_div_b", bus.div_b, TWO);
    tick();
    chk("norm_no_start_t3", 64'(bus.div_start), 64'd0);
    for (int i = 0; i < LATENCY - 1; i++) tick();
    chk("norm_not_valid_early", 64'(bus.out_valid), 64'd0);
    tick();
    chk("norm_valid", 64'(bus.out_valid), 64'd1);
    chk("norm_out_z", bus.out_z, 64'h4008_0000_0000_0000);
    chk("norm_out_special", 64'(bus.out_special), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("norm_valid_drop", 64'(bus.out_valid), 64'd0);

    // Special operands bypass the divider and are valid two cycles after the push.
    spA = '{ONE, MONE, 64'd0, ANAN, 64'h0000_0000_0000_0001};
    spB = '{64'd0, PINF, 64'd0, TWO, TWO};
    spZ = '{PINF, 64'h8000_0000_0000_0000, QNAN, QNAN, 64'd0};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      startsBefore = divStarts;
      push1(spA[k], spB[k]);
      chk("sp_not_valid_t1", 64'(bus.out_valid), 64'd0);
      tick();
      chk("sp_valid_t2", 64'(bus.out_valid), 64'd1);
      chk("sp_out_z", bus.out_z, spZ[k]);
      chk("sp_out_special", 64'(bus.out_special), 64'd1);
      tick();
      chk("sp_no_div_start", 64'(divStarts), 64'(startsBefore));
    end
    bus.out_ready = 1'b0;

    // Ordering: a special queued behind a division leaves after it.
    ordA = '{SIX, ONE, ONE};
    ordB = '{TWO, 64'd0, FOUR};
    ordZ = '{64'h4008_0000_0000_0000, PINF, 64'h3FD0_0000_0000_0000};
    ordSp = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) push1(ordA[k], ordB[k]);
    for (int k = 0; k < 3; k++) begin
      waitValid(LATENCY + 10, "ord_valid");
      chk("ord_out_z", bus.out_z, ordZ[k]);
      chk("ord_out_special", 64'(bus.out_special), 64'(ordSp[k]));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end

    // Backpressure: DEPTH queued plus one held, then a full FIFO refuses a push during a pop.
    bpA = '{ONE, MONE, 64'd0, ANAN, PINF, TWO};
    bpB = '{64'd0, 64'd0, TWO, ONE, TWO, NINF};
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a = bpA[accepted];
      bus.in_b = bpB[accepted];
      if (bus.in_ready) accepted++;
      tick();
    end
    chk("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
    chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_refuse_on_pop", 64'(bus.in_ready), 64'd0);
    tick();
    chk("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && (expQ.size() != 0 || bus.out_valid); i++) tick();
    chk("bp_drained", 64'(expQ.size()), 64'd0);
    bus.out_ready = 1'b0;

    // Reset in the middle of a division with two pairs queued.
    push1(SIX, TWO);
    push1(FOUR, TWO);
    push1(ONE, FOUR);
    for (int i = 0; i < 5; i++) tick();
    startsBefore = divStarts;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_div_start", 64'(bus.div_start), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    expQ.delete();
    prevValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rst_release_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    seenValid = 0;
    for (int i = 0; i < LATENCY + 10; i++) begin
      if (bus.out_valid) seenValid++;
      tick();
    end
    chk("mid_rst_no_result", 64'(seenValid), 64'd0);
    chk("mid_rst_no_issue", 64'(divStarts), 64'(startsBefore));
    push1(FOUR, TWO);
    waitValid(LATENCY + 10, "mid_rst_next_valid");
    chk("mid_rst_next_z", bus.out_z, TWO);
    tick();
    chk("mid_rst_queue_empty", 64'(expQ.size()), 64'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_a      = randOp();
      bus.in_b      = randOp();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < (DEPTH + 2) * (LATENCY + 3) + 20 && (expQ.size() != 0 || bus.out_valid); i++)
      tick();
    chk("rand_drained", 64'(expQ.size()), 64'd0);
    chk("rand_idle", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
